// File: rtl/clk_div_bank_pkg.sv
// Shared types and clamp helpers for the clk_div_bank divided-clock generator.
// Helpers work on 32-bit values; callers size the results back to DIV_W.
package clk_div_bank_pkg;

   typedef enum logic [1:0] {
      ST_ALIGN  = 2'd0,
      ST_SETTLE = 2'd1,
      ST_LOCKED = 2'd2
   } state_t;

   localparam int CHAN_IDX_W = 5;

   function automatic logic [31:0] clamp_div(input logic [31:0] div);
      return (div < 32'd2) ? 32'd2 : div;
   endfunction

   function automatic logic [31:0] clamp_phase(input logic [31:0] phase, input logic [31:0] div);
      return (phase >= div) ? (div - 32'd1) : phase;
   endfunction

   function automatic logic [31:0] clamp_high(input logic [31:0] high, input logic [31:0] div);
      logic [31:0] v;
      if (high == 32'd0) begin
         v = 32'd1;
      end else if (high >= div) begin
         v = div - 32'd1;
      end else begin
         v = high;
      end
      return v;
   endfunction

endpackage

// File: rtl/clk_div_bank_chan.sv
// One divider channel: shadow div/phase/high, free-running counter and registered output.
// The counter is reloaded with the phase whenever the bank realigns.
module clk_div_chan #(
   parameter int DIV_W       = 8,
   parameter int DEFAULT_DIV = 2
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_align,
   input  logic             i_wr,
   input  logic [DIV_W-1:0] i_div,
   input  logic [DIV_W-1:0] i_phase,
   input  logic [DIV_W-1:0] i_high,
   output logic             o_clk
);

   localparam logic [DIV_W-1:0] RST_DIV  = DIV_W'(DEFAULT_DIV);
   localparam logic [DIV_W-1:0] RST_HIGH = DIV_W'(DEFAULT_DIV >> 1);

   logic [DIV_W-1:0] r_div;
   logic [DIV_W-1:0] r_phase;
   logic [DIV_W-1:0] r_high;
   logic [DIV_W-1:0] r_cnt;
   logic             r_clk;

   // Shadow update, counter with wrap (or phase reload) and output compare.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_div   <= RST_DIV;
         r_phase <= {DIV_W{1'b0}};
         r_high  <= RST_HIGH;
         r_cnt   <= {DIV_W{1'b0}};
         r_clk   <= 1'b0;
      end else begin
         if (i_wr) begin
            r_div   <= i_div;
            r_phase <= i_phase;
            r_high  <= i_high;
         end else begin
            r_div   <= r_div;
            r_phase <= r_phase;
            r_high  <= r_high;
         end
         // A shrunk divide can leave the counter past the new wrap point; >= catches it.
         if (i_align) begin
            r_cnt <= r_phase;
         end else if (r_cnt >= (r_div - DIV_W'(1))) begin
            r_cnt <= {DIV_W{1'b0}};
         end else begin
            r_cnt <= r_cnt + DIV_W'(1);
         end
         r_clk <= (r_cnt < r_high);
      end
   end

   assign o_clk = r_clk;

endmodule

// File: rtl/clk_div_bank.sv
// Bank of NUM_CLOCKS phase-aligned refclk dividers with an ALIGN/SETTLE/LOCKED sequencer.
// Define CLK_DIV_BANK_DUTY_EN to use the programmed cfg_high; otherwise high time is div/2.
module clk_div_bank
   import clk_div_bank_pkg::*;
#(
   parameter int NUM_CLOCKS  = 4,
   parameter int DIV_W       = 8,
   parameter int DEFAULT_DIV = 2,
   parameter int LOCK_CYCLES = 16
) (
   input  logic                  refclk,
   input  logic                  rst,
   input  logic                  cfg_valid,
   output logic                  cfg_ready,
   input  logic [CHAN_IDX_W-1:0] cfg_chan,
   input  logic [DIV_W-1:0]      cfg_div,
   input  logic [DIV_W-1:0]      cfg_phase,
   input  logic [DIV_W-1:0]      cfg_high,
   output logic [NUM_CLOCKS-1:0] outclk,
   output logic                  locked
);

   localparam logic [15:0] SETTLE_LAST = 16'(LOCK_CYCLES - 1);

   state_t                r_state;
   logic [15:0]           r_settle_cnt;
   logic                  r_locked;
   logic                  r_cfg_ready;
   logic                  w_accept;
   logic                  w_align;
   logic [DIV_W-1:0]      w_div_c;
   logic [DIV_W-1:0]      w_phase_c;
   logic [DIV_W-1:0]      w_high_c;
   logic [NUM_CLOCKS-1:0] w_wr;
   logic [NUM_CLOCKS-1:0] w_outclk;

   assign w_accept  = cfg_valid & r_cfg_ready;
   assign w_align   = (r_state == ST_ALIGN);
   assign w_div_c   = DIV_W'(clamp_div(32'(cfg_div)));
   assign w_phase_c = DIV_W'(clamp_phase(32'(cfg_phase), 32'(w_div_c)));

`ifdef CLK_DIV_BANK_DUTY_EN
   assign w_high_c = DIV_W'(clamp_high(32'(cfg_high), 32'(w_div_c)));
`else
   logic w_unused_high;
   assign w_unused_high = ^cfg_high;
   assign w_high_c      = w_div_c >> 1;
`endif

   // Sequencer: one ALIGN cycle, LOCK_CYCLES of SETTLE, then LOCKED until a write lands.
   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         r_state      <= ST_ALIGN;
         r_settle_cnt <= 16'd0;
         r_locked     <= 1'b0;
         r_cfg_ready  <= 1'b0;
      end else begin
         case (r_state)
            ST_ALIGN: begin
               r_state      <= ST_SETTLE;
               r_settle_cnt <= 16'd0;
               r_locked     <= 1'b0;
               r_cfg_ready  <= 1'b0;
            end
            ST_SETTLE: begin
               if (r_settle_cnt == SETTLE_LAST) begin
                  r_state      <= ST_LOCKED;
                  r_settle_cnt <= 16'd0;
               end else begin
                  r_state      <= ST_SETTLE;
                  r_settle_cnt <= r_settle_cnt + 16'd1;
               end
               r_locked    <= 1'b0;
               r_cfg_ready <= 1'b0;
            end
            ST_LOCKED: begin
               r_settle_cnt <= 16'd0;
               if (w_accept) begin
                  r_state     <= ST_ALIGN;
                  r_locked    <= 1'b0;
                  r_cfg_ready <= 1'b0;
               end else begin
                  r_state     <= ST_LOCKED;
                  r_locked    <= 1'b1;
                  r_cfg_ready <= 1'b1;
               end
            end
            default: begin
               r_state      <= ST_ALIGN;
               r_settle_cnt <= 16'd0;
               r_locked     <= 1'b0;
               r_cfg_ready  <= 1'b0;
            end
         endcase
      end
   end

   // Out-of-range channel indices match no channel, so the write is dropped but still realigns.
   for (genvar g = 0; g < NUM_CLOCKS; g++) begin : g_chan
      assign w_wr[g] = w_accept && (cfg_chan == CHAN_IDX_W'(g));

      clk_div_chan #(
         .DIV_W       (DIV_W),
         .DEFAULT_DIV (DEFAULT_DIV)
      ) u_chan (
         .i_clk   (refclk),
         .i_rst   (rst),
         .i_align (w_align),
         .i_wr    (w_wr[g]),
         .i_div   (w_div_c),
         .i_phase (w_phase_c),
         .i_high  (w_high_c),
         .o_clk   (w_outclk[g])
      );
   end

   assign outclk    = w_outclk;
   assign locked    = r_locked;
   assign cfg_ready = r_cfg_ready;

endmodule

// File: tb/tb_clk_div_bank.sv
// Scoreboard bench for clk_div_bank: a per-edge arithmetic model queues expectations,
// a negedge monitor pops and compares them against the outputs.
module tb_clk_div_bank;

   localparam int NUM_CLOCKS  = 4;
   localparam int DIV_W       = 8;
   localparam int DEFAULT_DIV = 2;
   localparam int LOCK_CYCLES = 16;

   logic                  refclk    = 1'b0;
   logic                  rst       = 1'b1;
   logic                  cfg_valid = 1'b0;
   logic [4:0]            cfg_chan  = 5'd0;
   logic [DIV_W-1:0]      cfg_div   = '0;
   logic [DIV_W-1:0]      cfg_phase = '0;
   logic [DIV_W-1:0]      cfg_high  = '0;
   logic                  cfg_ready;
   logic                  locked;
   logic [NUM_CLOCKS-1:0] outclk;

   always #5 refclk = ~refclk;

   clk_div_bank #(
      .NUM_CLOCKS  (NUM_CLOCKS),
      .DIV_W       (DIV_W),
      .DEFAULT_DIV (DEFAULT_DIV),
      .LOCK_CYCLES (LOCK_CYCLES)
   ) dut (
      .refclk    (refclk),
      .rst       (rst),
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .cfg_chan  (cfg_chan),
      .cfg_div   (cfg_div),
      .cfg_phase (cfg_phase),
      .cfg_high  (cfg_high),
      .outclk    (outclk),
      .locked    (locked)
   );

   typedef struct {
      logic                  lk;
      logic                  rdy;
      logic [NUM_CLOCKS-1:0] oc;
      bit                    chk_oc;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   bit   timeout_flag = 1'b0;

   // Reference model state: effective settings per channel and the edge index of the last ALIGN.
   int m_div [NUM_CLOCKS];
   int m_ph  [NUM_CLOCKS];
   int m_hi  [NUM_CLOCKS];
   int m_edge    = 0;
   int m_align   = 0;
   bit m_pending = 1'b1;
   bit m_ready   = 1'b0;

   function automatic void m_reset();
      for (int i = 0; i < NUM_CLOCKS; i++) begin
         m_div[i] = DEFAULT_DIV;
         m_ph[i]  = 0;
         m_hi[i]  = DEFAULT_DIV / 2;
      end
      m_pending = 1'b1;
      m_ready   = 1'b0;
   endfunction

   // Model: sample inputs at the edge, then after a short delay fold in any async reset and queue the expectation.
   always @(posedge refclk) begin : model
      exp_t e;
      bit   v, r;
      int   ch, dv, ph, hi, d, t;
      v  = cfg_valid;
      r  = rst;
      ch = int'(cfg_chan);
      dv = int'(cfg_div);
      ph = int'(cfg_phase);
      hi = int'(cfg_high);
      m_edge++;
      if (r) begin
         m_reset();
      end else if (m_pending) begin
         m_pending = 1'b0;
         m_align   = m_edge;
      end else if (v && m_ready) begin
         if (ch < NUM_CLOCKS) begin
            d = (dv < 2) ? 2 : dv;
            m_div[ch] = d;
            m_ph[ch]  = (ph >= d) ? d - 1 : ph;
`ifdef CLK_DIV_BANK_DUTY_EN
            m_hi[ch]  = (hi == 0) ? 1 : ((hi >= d) ? d - 1 : hi);
`else
            m_hi[ch]  = d / 2;
`endif
         end
         m_align = m_edge + 1;
      end
      #3;
      if (rst) m_reset();
      if (m_pending) begin
         e.lk = 1'b0; e.rdy = 1'b0; e.oc = '0; e.chk_oc = 1'b1;
      end else begin
         m_ready  = (m_edge >= m_align + 1 + LOCK_CYCLES);
         e.lk     = m_ready;
         e.rdy    = m_ready;
         t        = m_edge - m_align;
         e.chk_oc = (t >= 1);
         e.oc     = '0;
         for (int i = 0; i < NUM_CLOCKS; i++)
            e.oc[i] = (t >= 1) && (((m_ph[i] + t - 1) % m_div[i]) < m_hi[i]);
      end
      exp_q.push_back(e);
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
      end
   endtask

   // Monitor: compare the outputs with the oldest queued expectation each cycle.
   always @(negedge refclk) begin : monitor
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("locked", 32'(locked), 32'(e.lk));
         chk("cfg_ready", 32'(cfg_ready), 32'(e.rdy));
         if (e.chk_oc) chk("outclk", 32'(outclk), 32'(e.oc));
      end
      chk("handshake_timeout", 32'(timeout_flag), 32'd0);
   end

   task automatic idle(input int n);
      repeat (n) @(posedge refclk);
      #1;
   endtask

   task automatic do_write(input int ch, input int dv, input int ph, input int hi);
      int k;
      cfg_chan  = 5'(ch);
      cfg_div   = DIV_W'(dv);
      cfg_phase = DIV_W'(ph);
      cfg_high  = DIV_W'(hi);
      cfg_valid = 1'b1;
      for (k = 0; k < 300; k++) begin
         @(negedge refclk);
         if (cfg_ready === 1'b1) break;
      end
      if (k == 300) timeout_flag = 1'b1;
      @(posedge refclk);
      #1;
      cfg_valid = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      repeat (3) @(posedge refclk);
      #1 rst = 1'b0;
      idle(30);
      do_write(1, 5, 2, 0);
      idle(40);
      do_write(2, 0, 0, 0);
      idle(25);
      do_write(7, 3, 1, 1);
      idle(25);
      // Second request is raised while the first one's relock is still in progress.
      do_write(0, 3, 1, 0);
      do_write(3, 4, 3, 0);
      idle(25);
      do_write(2, 6, 9, 0);
      idle(5);
      #1 rst = 1'b1;
      repeat (2) @(posedge refclk);
      #1 rst = 1'b0;
      idle(30);
      do_write(3, 8, 0, 6);
      idle(40);
      do_write(3, 8, 1, 0);
      idle(40);
      for (int i = 0; i < 25; i++) begin
         do_write(int'($urandom_range(0, 7)), int'($urandom_range(0, 12)),
                  int'($urandom_range(0, 15)), int'($urandom_range(0, 12)));
         idle(int'($urandom_range(0, 30)));
      end
      idle(40);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
